// File: rtl/mux2a1_cond_l2_pkg.sv
`default_nettype none
// ============================================================================
// mux_l2_pkg : shared constants and lane-select type for the L2 2-to-1 combiner
// Rev 1.0
// ============================================================================
package mux_l2_pkg;

   localparam int          DEF_DEPTH = 4;
   localparam int          DEF_WIDTH = 8;
   localparam logic [7:0]  IDLE_BYTE = 8'hBC;

   typedef enum logic {
      LANE0 = 1'b0,
      LANE1 = 1'b1
   } lane_sel_t;

   function automatic lane_sel_t toggle_lane(input lane_sel_t l);
      return (l == LANE0) ? LANE1 : LANE0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux2a1_cond_l2_if.sv
`default_nettype none
// ============================================================================
// mux2a1_cond_l2_if : two input lanes in, one interleaved stream and status out
// Rev 1.0
// ============================================================================
interface mux2a1_cond_l2_if
   import mux_l2_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             valid_in0;
   logic [WIDTH-1:0] data_in0;
   logic             valid_in1;
   logic [WIDTH-1:0] data_in1;
   logic             valid_out;
   logic [WIDTH-1:0] data_out;
   logic             selector;
   logic             full0;
   logic             full1;
   logic             overflow;

   modport slave (
      input  valid_in0, data_in0, valid_in1, data_in1,
      output valid_out, data_out, selector, full0, full1, overflow
   );

   modport master (
      output valid_in0, data_in0, valid_in1, data_in1,
      input  valid_out, data_out, selector, full0, full1, overflow
   );
endinterface
`default_nettype wire

// File: rtl/mux2a1_cond_l2_fifo.sv
`default_nettype none
// ============================================================================
// fifo_lane_l2 : per-lane buffer; a push into a full lane is dropped unless the
// same edge also pops. Rev 1.0
// ============================================================================
module fifo_lane_l2
   import mux_l2_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_pop,
   output logic      [WIDTH-1:0] o_data,
   output logic                  o_empty,
   output logic                  o_full,
   output logic                  o_drop
);
   localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             CW      = AW + 1;
   localparam logic [CW-1:0]  C_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic             w_pop;
   logic             w_push_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == C_DEPTH);
   assign o_data    = r_mem[r_rd_ptr];

   assign w_pop     = i_pop && !o_empty;
   // The slot freed by a same-edge pop is what lets a full lane accept a push.
   assign w_push_ok = i_push && (!o_full || w_pop);
   assign o_drop    = i_push && !w_push_ok;

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux2a1_cond_l2.sv
`default_nettype none
// ============================================================================
// mux2a1_cond_l2 : strict lane0/lane1 interleaver; MUXL2_IDLE_FILL_EN drives
// IDLE_BYTE on data_out while valid_out is low. Rev 1.0
// ============================================================================
module mux2a1_cond_l2
   import mux_l2_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
) (
   input  wire logic        clk_4f,
   input  wire logic        reset,
   mux2a1_cond_l2_if.slave  bus
);
`ifdef MUXL2_IDLE_FILL_EN
   localparam logic [WIDTH-1:0] C_RST_DATA = WIDTH'(IDLE_BYTE);
`else
   localparam logic [WIDTH-1:0] C_RST_DATA = '0;
`endif

   logic             w_empty0, w_empty1;
   logic             w_full0,  w_full1;
   logic             w_drop0,  w_drop1;
   logic [WIDTH-1:0] w_head0,  w_head1;
   logic             w_pop0,   w_pop1;

   logic             w_head_empty;
   logic [WIDTH-1:0] w_head;
   logic             w_pop;
   lane_sel_t        w_sel_nxt;

   lane_sel_t        r_sel;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_ovf;

   fifo_lane_l2 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_lane0 (
      .clk     (clk_4f),
      .rst     (reset),
      .i_push  (bus.valid_in0),
      .i_data  (bus.data_in0),
      .i_pop   (w_pop0),
      .o_data  (w_head0),
      .o_empty (w_empty0),
      .o_full  (w_full0),
      .o_drop  (w_drop0)
   );

   fifo_lane_l2 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_lane1 (
      .clk     (clk_4f),
      .rst     (reset),
      .i_push  (bus.valid_in1),
      .i_data  (bus.data_in1),
      .i_pop   (w_pop1),
      .o_data  (w_head1),
      .o_empty (w_empty1),
      .o_full  (w_full1),
      .o_drop  (w_drop1)
   );

   assign w_head_empty = (r_sel == LANE0) ? w_empty0 : w_empty1;
   assign w_head       = (r_sel == LANE0) ? w_head0  : w_head1;
   assign w_pop0       = w_pop && (r_sel == LANE0);
   assign w_pop1       = w_pop && (r_sel == LANE1);

   // Stall on the expected lane rather than skip: that is what keeps byte order.
   always_comb begin
      w_pop     = 1'b0;
      w_sel_nxt = r_sel;
      if (!w_head_empty) begin
         w_pop     = 1'b1;
         w_sel_nxt = toggle_lane(r_sel);
      end
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_sel <= LANE0;
      end else begin
         r_sel <= w_sel_nxt;
      end
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_data  <= C_RST_DATA;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= w_pop;
         if (w_pop) begin
            r_data <= w_head;
`ifdef MUXL2_IDLE_FILL_EN
         end else begin
            r_data <= WIDTH'(IDLE_BYTE);
`endif
         end
         r_ovf <= r_ovf | w_drop0 | w_drop1;
      end
   end

   assign bus.valid_out = r_valid;
   assign bus.data_out  = r_data;
   assign bus.selector  = (r_sel == LANE1);
   assign bus.full0     = w_full0;
   assign bus.full1     = w_full1;
   assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: doc/mux2a1_cond_l2.md
Name: mux2a1_cond_l2

Overview:
- Layer-2 combiner: the transmit-side counterpart of the L2 1-to-2 demux.
- Takes two 8-bit lanes, each with its own valid, and interleaves them onto one 8-bit stream.
- Output order is strictly lane0, lane1, lane0, ..., mirroring the demux's alternating split so the original byte order is restored.
- Sits between the two L1 lane outputs and the serializer, all in the clk_4f domain.

Parameters:
- DEPTH, 4, entries per lane buffer; power of two, minimum 2.
- WIDTH, 8, data width in bits.

Ports:
- clk_4f  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid_in0  in  1  data_in0 holds a valid byte this cycle.
- data_in0  in  WIDTH  lane-0 byte.
- valid_in1  in  1  data_in1 holds a valid byte this cycle.
- data_in1  in  WIDTH  lane-1 byte.
- valid_out  out  1  data_out holds a valid byte this cycle.
- data_out  out  WIDTH  interleaved byte.
- selector  out  1  lane that the next emitted byte comes from.
- full0  out  1  lane-0 buffer holds DEPTH entries.
- full1  out  1  lane-1 buffer holds DEPTH entries.
- overflow  out  1  sticky flag: a byte was dropped.

Behaviour:
- Reset (asynchronous, active-high): buffers empty, pointers 0, selector=0, valid_out=0, data_out=0, full0=full1=0, overflow=0. Reset asserted mid-stream discards all buffered bytes immediately; operation restarts from lane 0.
- Push: valid_inN=1 writes data_inN into lane N's FIFO at the rising edge.
- Pop: a pop occurs in a cycle when lane[selector] is non-empty.
  - The head byte is registered into data_out with valid_out=1 on the next edge.
  - selector toggles on each pop.
  - If lane[selector] is empty: no pop, valid_out=0 next cycle, selector holds. The combiner stalls on the expected lane and never skips to the other lane; this is what preserves ordering.
- Bypass is not provided. Latency from push to output is 2 edges: the push edge, then the pop edge, observed at data_out after the second edge. Example: push at edge k into an empty, selected lane; data_out is valid after edge k+1.
- Simultaneous push and pop on the same lane: both take effect, occupancy is unchanged, and pushing into a full lane succeeds in this case.
- Push into a full lane with no same-cycle pop: the byte is dropped, buffer contents are unchanged, overflow sets and stays 1 until reset.
- Pointer arithmetic: wr/rd pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits; full when occupancy==DEPTH, empty when occupancy==0.
- full0/full1 are registered and reflect occupancy after the current edge.
- While valid_out=0, data_out holds its last value (see the optional feature).
- Sustained throughput: one byte per cycle when both lanes each supply one byte every 2 cycles.

Optional Feature:
- MUXL2_IDLE_FILL_EN
  - Defined: whenever valid_out=0, data_out is driven to the idle byte IDLE_BYTE (8'hBC), including after reset.
  - Undefined: data_out holds its previous value while idle and resets to 0.

Decomposition:
- Package mux_l2_pkg holds:
  - the IDLE_BYTE constant;
  - the default DEPTH and WIDTH;
  - a lane_sel_t typedef (1-bit enum, LANE0/LANE1).
- One sub-module, fifo_lane_l2, is instantiated twice (push, pop, data_out, empty, full, drop).
- The top holds the selector register, the pop logic, the output register and the overflow latch.

Test Plan:
- Reset, then push 8'h00 on lane0 and 8'h01 on lane1 in the same cycle, then 8'h02/8'h03 two cycles later → data_out sequence 00,01,02,03 on consecutive cycles, first valid 2 edges after the first push.
- Push 8'hA0 and 8'hA2 on lane0 only, no lane1 traffic → A0 emitted, then valid_out=0 with selector=1 stalled; push 8'hA1 on lane1 → A1 then A2 emitted.
- Push 5 bytes 10..14 into lane1 while lane0 stays empty (DEPTH=4) → full1=1 after 4 pushes, byte 14 dropped, overflow=1; after lane0 supplies 4 bytes the output shows 10..13 only, and overflow remains 1.
- Lane1 full and selector=1 popping while valid_in1 pushes 8'h55 in the same cycle → push accepted, full1 stays 1, overflow stays 0, and 55 later appears in order.
- Assert reset mid-stream with bytes buffered → valid_out=0, full0=full1=0, overflow=0, selector=0 immediately (asynchronously); the next lane0 byte is the first emitted.
- With MUXL2_IDLE_FILL_EN defined → data_out=8'hBC whenever valid_out=0, including after reset; without it, data_out holds its last byte.
